router_pkt_tx: RTL

Packet transmitter for the router input port. It accepts a packet request (destination, length), collects the payload bytes into an internal buffer, and then drives the router's input byte stream: header, payload, parity. The router's `busy` is honoured on every byte. It sits between the test or host traffic source and the router top-level input (`pkt_valid`, `data_in`, `busy`).

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_tx_buf.sv | 68 ++++++
 rtl/router_pkt_tx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// router_pkg
//   Shared definitions for the router packet transmitter and its peers.
//   - tx_state_t   : transmitter FSM states
//   - DEST_ILLEGAL : destination code that is never routed
//   - hdr_byte()   : header layout {len[5:0], dest[1:0]}
package router_pkg;

    localparam logic [1:0] DEST_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY
    } tx_state_t;

    // Length in [7:2], destination in [1:0].
    function automatic logic [7:0] hdr_byte(input logic [1:0] dest,
                                            input logic [5:0] len);
        return {len, dest};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// router_tx_buf
//   Synchronous FIFO holding one packet payload, first-word-fall-through.
//   Ports:
//     clock, reset   : clock, synchronous active-high reset
//     clear          : synchronous flush (packet abort)
//     push, din      : write request and data (ignored when full)
//     pop            : read request (ignored when empty)
//     dout           : current head entry
//     count          : occupancy, ADDR_W+1 bits
//     empty, full    : occupancy flags
module router_tx_buf #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx
//   Collects a packet payload, then drives header / payload / parity onto
//   the router input stream, honouring busy on every byte.
//   Ports:
//     clock, reset          : clock, synchronous active-high reset
//     req_valid/ready       : request handshake with req_dest, req_len
//     pay_valid/ready       : payload handshake with pay_data
//     busy                  : router stall, holds the driven byte
//     soft_reset            : aborts the packet in flight
//     pkt_valid, data_in    : registered router input stream
//     done                  : pulse after the parity byte is accepted
//     drop                  : pulse after an illegal-destination request
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_dest,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              pay_valid,
    output logic              pay_ready,
    input  logic [DATA_W-1:0] pay_data,
    input  logic              busy,
    input  logic              soft_reset,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_in,
    output logic              done,
    output logic              drop
);

    localparam int unsigned CNT_W = LEN_W + 1;

    tx_state_t         state;
    logic [1:0]        dest_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] parity;

    logic              abort;
    logic              pay_take;
    logic              buf_pop;
    logic [DATA_W-1:0] buf_dout;
    logic [CNT_W-1:0]  buf_count;
    logic              buf_empty;
    logic              buf_full;

    assign abort     = soft_reset && (state != ST_IDLE);
    assign req_ready = (state == ST_IDLE) && !reset;
    assign pay_ready = (state == ST_LOAD) && (buf_count < {1'b0, len_q}) && !buf_full;
    assign pay_take  = pay_valid && pay_ready && !abort;

    // The head is popped as it is copied into data_in, so the buffer is
    // drained by the time the last payload byte is accepted.
    assign buf_pop = !abort && !busy &&
                     (((state == ST_HEADER) && (len_q != '0)) ||
                      ((state == ST_PAYLOAD) && !buf_empty));

    router_tx_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (LEN_W)
    ) u_buf (
        .clock (clock),
        .reset (reset),
        .clear (abort),
        .push  (pay_take),
        .din   (pay_data),
        .pop   (buf_pop),
        .dout  (buf_dout),
        .count (buf_count),
        .empty (buf_empty),
        .full  (buf_full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            dest_q    <= '0;
            len_q     <= '0;
            parity    <= '0;
            pkt_valid <= 1'b0;
            data_in   <= '0;
            done      <= 1'b0;
            drop      <= 1'b0;
        end else begin
            done <= 1'b0;
            drop <= 1'b0;
            if (abort) begin
                state     <= ST_IDLE;
                len_q     <= '0;
                parity    <= '0;
                pkt_valid <= 1'b0;
                data_in   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req_valid) begin
                            if (req_dest == DEST_ILLEGAL) begin
                                drop <= 1'b1;
                            end else begin
                                dest_q <= req_dest;
                                len_q  <= req_len;
                                parity <= hdr_byte(req_dest, req_len);
                                if (req_len == '0) begin
                                    state     <= ST_HEADER;
                                    pkt_valid <= 1'b1;
                                    data_in   <= hdr_byte(req_dest, req_len);
                                end else begin
                                    state <= ST_LOAD;
                                end
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (pay_take) begin
                            parity <= parity ^ pay_data;
                            if (buf_count + CNT_W'(1) == {1'b0, len_q}) begin
                                state     <= ST_HEADER;
                                pkt_valid <= 1'b1;
                                data_in   <= hdr_byte(dest_q, len_q);
                            end
                        end
                    end
                    ST_HEADER: begin
                        if (!busy) begin
                            if (len_q == '0) begin
                                state     <= ST_PARITY;
                                pkt_valid <= 1'b0;
                                data_in   <= parity;
                            end else begin
                                state   <= ST_PAYLOAD;
                                data_in <= buf_dout;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (!busy) begin
                            if (buf_empty) begin
                                state     <= ST_PARITY;
                                pkt_valid <= 1'b0;
                                data_in   <= parity;
                            end else begin
                                data_in <= buf_dout;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (!busy) begin
                            state   <= ST_IDLE;
                            done    <= 1'b1;
                            data_in <= '0;
                            parity  <= '0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
